// File: rtl/multicycle_core.sv
// multicycle_core: FETCH/DECODE/EXEC/MEM/WB core on one handshaked bus.
// Define CORE_BNE_EN to make op 000101 (bne) a legal branch.
module multicycle_core #(
  parameter int DATA_WIDTH = 16,
  parameter int PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_req,
  output logic                mem_we,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic                mem_ack,
  input  logic [31:0]         mem_rdata,
  output logic [PC_WIDTH-1:0] pc,
  output logic                retire,
  output logic                halted
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
`ifdef CORE_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t state, state_d;

  logic [31:0]           ir;
  logic [DATA_WIDTH-1:0] rf [32];
  logic [DATA_WIDTH-1:0] a_q, b_q, res_q;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, dst;
  logic [15:0] imm;
  logic [25:0] target;

  logic is_r, is_addi, is_lw, is_sw;
  logic is_beq, is_bne, is_j;
  logic r_ok, legal, ctl_flow, is_mem, take_br;
  logic accept;

  logic [DATA_WIDTH-1:0] imm_x, alu_y;
  logic [PC_WIDTH-1:0]   br_pc, j_pc, pc_nxt;

  logic                start, st_we, retire_d;
  logic [PC_WIDTH-1:0] st_addr;
  logic [31:0]         st_wd;

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign imm    = ir[15:0];
  assign target = ir[25:0];
  assign accept = mem_req & mem_ack;
  assign halted = (state == S_HALT);

  // Opcode classification and legality of the latched instruction
  always_comb begin
    is_r    = (op == OP_R);
    is_addi = (op == OP_ADDI);
    is_lw   = (op == OP_LW);
    is_sw   = (op == OP_SW);
    is_beq  = (op == OP_BEQ);
    is_j    = (op == OP_J);
`ifdef CORE_BNE_EN
    is_bne  = (op == OP_BNE);
`else
    is_bne  = 1'b0;
`endif
    r_ok = (funct == F_ADD) || (funct == F_SUB) ||
           (funct == F_AND) || (funct == F_OR) ||
           (funct == F_SLT);
    legal = (is_r && r_ok) || is_addi || is_lw ||
            is_sw || is_beq || is_j || is_bne;
    ctl_flow = is_beq | is_bne | is_j;
    is_mem   = is_lw | is_sw;
    dst      = is_r ? rd : rt;
  end

  // ALU and next-PC computation on latched operands
  always_comb begin
    imm_x = DATA_WIDTH'($signed(imm));
    alu_y = a_q + imm_x;
    if (is_r) begin
      unique case (funct)
        F_SUB:   alu_y = a_q - b_q;
        F_AND:   alu_y = a_q & b_q;
        F_OR:    alu_y = a_q | b_q;
        F_SLT:   alu_y = DATA_WIDTH'($signed(a_q) < $signed(b_q));
        default: alu_y = a_q + b_q;
      endcase
    end
    take_br = (is_beq && (a_q == b_q)) ||
              (is_bne && (a_q != b_q));
    br_pc = pc + (take_br ? PC_WIDTH'($signed(imm)) : '0);
    j_pc = pc;
    j_pc[25:0] = target;
    pc_nxt = is_j ? j_pc : br_pc;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_d;
  end

  // Next state, bus launch and retire decisions
  always_comb begin
    state_d  = state;
    start    = 1'b0;
    st_we    = 1'b0;
    st_addr  = pc;
    st_wd    = '0;
    retire_d = 1'b0;
    unique case (state)
      S_FETCH: begin
        start = !mem_req;
        if (accept) state_d = S_DECODE;
      end
      S_DECODE: state_d = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        unique case (1'b1)
          ctl_flow: begin
            state_d  = S_FETCH;
            start    = 1'b1;
            st_addr  = pc_nxt;
            retire_d = 1'b1;
          end
          is_mem: begin
            state_d = S_MEM;
            start   = 1'b1;
            st_we   = is_sw;
            st_addr = PC_WIDTH'(alu_y);
            st_wd   = is_sw ? 32'(b_q) : '0;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (accept) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            state_d  = S_FETCH;
            start    = 1'b1;
            retire_d = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d  = S_FETCH;
        start    = 1'b1;
        retire_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Bus registers, PC, operand latches and register file
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retire    <= 1'b0;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      retire <= retire_d;
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= st_we;
        mem_addr  <= st_addr;
        mem_wdata <= st_wd;
      end else if (accept) begin
        mem_req <= 1'b0;
      end
      if (state == S_FETCH && accept) begin
        ir <= mem_rdata;
        pc <= pc + PC_WIDTH'(1);
      end
      if (state == S_DECODE) begin
        a_q <= rf[rs];
        b_q <= rf[rt];
      end
      if (state == S_EXEC) begin
        res_q <= alu_y;
        if (ctl_flow) pc <= pc_nxt;
      end
      if (state == S_MEM && accept)
        res_q <= mem_rdata[DATA_WIDTH-1:0];
      if (state == S_WB && dst != 5'd0)
        rf[dst] <= res_q;
    end
  end

endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multi-cycle successor to the single-cycle CPU top. Executes the same 32-bit MIPS-style instruction format via a FETCH/DECODE/EXEC/MEM/WB state machine over one shared, handshaked memory port. Replaces separate instruction and data memories with a single bus that tolerates wait states. Sits between the system memory/arbiter and the testbench or SoC top.

## Interface
- DATA_WIDTH, 16, register/ALU width; legal 16..32
- PC_WIDTH, 32, PC and memory address width; legal 26..32
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- mem_req  output  1  transaction request; held until acknowledged
- mem_we  output  1  1 = write, 0 = read; valid while mem_req
- mem_addr  output  PC_WIDTH  word address; stable while mem_req
- mem_wdata  output  32  store data, zero-extended from DATA_WIDTH
- mem_ack  input  1  transaction completes on an edge where mem_req & mem_ack
- mem_rdata  input  32  read data, valid with mem_ack
- pc  output  PC_WIDTH  current PC
- retire  output  1  one-cycle pulse per completed instruction
- halted  output  1  core stopped on illegal opcode

## Operation
- Fields: op [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0], target [25:0].
- Register file: 32 x DATA_WIDTH. r0 reads 0 and ignores writes. Two async reads, one sync write in WB.
- imm is sign-extended to DATA_WIDTH. Arithmetic wraps modulo 2^DATA_WIDTH.
- R-type (op 000000): funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed). Writes rd. Any other funct is illegal.
- addi 001000: rt = rs + imm.
- lw 100011: rt = mem[rs+imm]. Load data is mem_rdata[DATA_WIDTH-1:0].
- sw 101011: mem[rs+imm] = rt.
- Data address: ALU result zero-extended to PC_WIDTH.
- beq 000100: if rs == rt, pc = pc+1+sext(imm), else pc+1.
- j 000010: pc = {(pc+1)[PC_WIDTH-1:26], target}.
- PC is word-addressed and increments by 1. Wrap at 2^PC_WIDTH.
- States:
  - FETCH: req read at pc; on ack latch IR, pc <= pc+1 → DECODE.
  - DECODE: latch rs/rt operands; illegal op → HALT, else → EXEC.
  - EXEC: ALU. beq/j update pc, retire → FETCH. R/addi → WB. lw/sw → MEM.
  - MEM: req at address; on ack: lw → WB, sw retire → FETCH.
  - WB: write register, retire → FETCH.
  - HALT: halted=1, no requests, until rst.
- A write to r0 is legal and does not change r0.

## Timing
- Reset values: pc=RESET_PC, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, halted=0, state FETCH, all registers 0.
- mem_req rises on the first cycle of FETCH or MEM. It drops on the cycle after the accepting edge.
- mem_addr, mem_we and mem_wdata are constant while mem_req is high.
- mem_ack while mem_req=0 is ignored.
- Zero-wait-state cycle counts: R/addi 4, lw 5, sw 4, beq/j 3. Each wait cycle of ack adds one.
- retire pulses high for the cycle following the completing edge.
- Next FETCH req is asserted in the same cycle as retire.
- rst overrides everything at any edge, including mid-transaction. mem_req is low on the cycle after rst is sampled.
- A lw whose rt equals the next instruction's rs sees the new value, because WB precedes the next DECODE.

## Configuration
- CORE_BNE_EN defined: op 000101 (bne) is legal. It branches when rs != rt, with the same target and 3-cycle timing as beq.
- CORE_BNE_EN undefined: op 000101 is illegal, so DECODE → HALT and halted=1.

## Test plan
- Reset with mem_ack tied 1: first req at addr 0, mem_we=0. pc=0 before the first accept and 1 after.
- Program addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2, zero wait: r3=2, 3 retire pulses over 12 cycles. Subtract r1-r2 gives 8.
- sw r1→addr 0x10 then lw r4 from 0x10, ack delayed 3 cycles each:
  - Write observed with wdata=5 and address stable throughout.
  - r4=5.
  - The lw takes 5+3+3 cycles (3 wait cycles on fetch, 3 on the data read).
- beq taken with imm=-1 at pc=4: next fetch at addr 4. Not-taken case fetches 5. j target 0x20: next fetch 0x20.
- Fetch word with op 000101:
  - With CORE_BNE_EN undefined: halted=1 and no further mem_req.
  - With it defined: branch behaves per the Operation section.
  - Assert rst during a stalled MEM with mem_req held: mem_req is low the next cycle and fetch restarts at RESET_PC.
